// File: rtl/axistream_snoop_arb.sv
// axistream_snoop_arb: merges NUM_CH passive AXIS taps into one snoop stream, whole packets, round-robin.
// Define SNOOP_ARB_DROP_CNT_EN to build the per-channel saturating drop counters; otherwise drop_cnt is 0.
module axistream_snoop_arb #(
  parameter int NUM_CH = 2,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int CNT_WIDTH = 16,
  localparam int W = SN_FWD_DATA_WIDTH,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_CH*W-1:0]           sn_TDATA,
  input  logic [NUM_CH*W/8-1:0]         sn_TKEEP,
  input  logic [NUM_CH-1:0]             sn_TREADY,
  input  logic [NUM_CH-1:0]             sn_TVALID,
  input  logic [NUM_CH-1:0]             sn_TLAST,
  output logic [W-1:0]                  out_TDATA,
  output logic [W/8-1:0]                out_TKEEP,
  output logic                          out_TVALID,
  output logic                          out_TLAST,
  output logic                          out_TREADY,
  output logic [CH_W-1:0]               out_chan,
  output logic                          busy,
  output logic [NUM_CH*CNT_WIDTH-1:0]   drop_cnt
);
  typedef enum logic {IDLE, FWD} state_t;
  state_t state, state_nxt;
  logic [CH_W-1:0] owner, owner_nxt, rr_ptr, rr_nxt, grant, sel;
  logic [NUM_CH-1:0] beat, sop, in_pkt, cand;
  logic take;
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] c, input logic [CH_W-1:0] p);
    rr_pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (c[(int'(p) + k) % NUM_CH]) rr_pick = CH_W'((int'(p) + k) % NUM_CH);
  endfunction
  assign beat = sn_TVALID & sn_TREADY;
  assign sop = beat & ~in_pkt;
  assign cand = (state == IDLE && enable) ? sop : '0;
  assign grant = rr_pick(cand, rr_ptr);
  assign sel = (state == IDLE) ? grant : owner;
  assign take = (state == IDLE) ? |cand : beat[owner];
  assign out_TREADY = 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt = rr_ptr;
    if (state == IDLE && take) begin
      rr_nxt = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      owner_nxt = grant;
      state_nxt = sn_TLAST[grant] ? IDLE : FWD;
    end else if (state == FWD && take && sn_TLAST[owner]) state_nxt = IDLE;
  end
  always_comb busy = (state == FWD);
  // packet tracking follows every beat, granted or not, so drops stay packet-aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_TVALID <= 1'b0;
      out_TLAST <= 1'b0;
      out_TDATA <= '0;
      out_TKEEP <= '0;
      out_chan <= '0;
      in_pkt <= '0;
    end else begin
      out_TVALID <= take;
      out_TLAST <= take & sn_TLAST[sel];
      if (take) begin
        out_TDATA <= sn_TDATA[sel*W +: W];
        out_TKEEP <= sn_TKEEP[sel*(W/8) +: W/8];
        out_chan <= sel;
      end
      in_pkt <= (in_pkt & ~beat) | (beat & ~sn_TLAST);
    end
`ifdef SNOOP_ARB_DROP_CNT_EN
  logic [NUM_CH-1:0] drop;
  assign drop = sop & ~((state == IDLE && take) ? (NUM_CH'(1) << grant) : '0);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (drop[g] && cnt != '1) cnt <= cnt + 1'b1;
    assign drop_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_axistream_snoop_arb.sv
// tb_axistream_snoop_arb: directed and random stimulus checked against a packet-level reference model
module tb_axistream_snoop_arb;
  localparam int N = 3, DW = 32, KW = DW / 8, CW = 3, CHW = 2;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [N*DW-1:0] sn_TDATA = '0;
  logic [N*KW-1:0] sn_TKEEP = '0;
  logic [N-1:0] sn_TREADY = '0, sn_TVALID = '0, sn_TLAST = '0;
  logic [DW-1:0] out_TDATA;
  logic [KW-1:0] out_TKEEP;
  logic out_TVALID, out_TLAST, out_TREADY, busy;
  logic [CHW-1:0] out_chan;
  logic [N*CW-1:0] drop_cnt;
  int total = 0, bad = 0;
  bit m_in[N];
  int m_cnt[N];
  int m_own, m_rr, x_chan;
  bit x_v, x_l;
  logic [DW-1:0] x_dat;
  logic [KW-1:0] x_keep;
  axistream_snoop_arb #(.NUM_CH(N), .SN_FWD_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sn_TDATA(sn_TDATA), .sn_TKEEP(sn_TKEEP), .sn_TREADY(sn_TREADY),
    .sn_TVALID(sn_TVALID), .sn_TLAST(sn_TLAST),
    .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TVALID(out_TVALID),
    .out_TLAST(out_TLAST), .out_TREADY(out_TREADY), .out_chan(out_chan),
    .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] r = '0;
`ifdef SNOOP_ARB_DROP_CNT_EN
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
`endif
    return r;
  endfunction
  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_in[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_own = -1;
    m_rr = 0;
    x_v = 1'b0;
    x_l = 1'b0;
    x_dat = '0;
    x_keep = '0;
    x_chan = 0;
  endtask
  task automatic fwd(input int c);
    x_v = 1'b1;
    x_l = sn_TLAST[c];
    x_dat = sn_TDATA[c*DW +: DW];
    x_keep = sn_TKEEP[c*KW +: KW];
    x_chan = c;
  endtask
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N-1:0] l, input bit en);
    logic [N-1:0] b, sop;
    int g;
    g = -1;
    @(negedge clk);
    sn_TVALID = v;
    sn_TREADY = r;
    sn_TLAST = l;
    enable = en;
    for (int i = 0; i < N; i++) begin
      sn_TDATA[i*DW +: DW] = $urandom;
      sn_TKEEP[i*KW +: KW] = KW'($urandom);
    end
    b = v & r;
    for (int i = 0; i < N; i++) sop[i] = b[i] & !m_in[i];
    x_v = 1'b0;
    x_l = 1'b0;
    if (m_own < 0) begin
      if (en)
        for (int k = 0; k < N; k++)
          if (g < 0 && sop[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        fwd(g);
        m_rr = (g + 1) % N;
        if (!l[g]) m_own = g;
      end
    end else if (b[m_own]) begin
      fwd(m_own);
      if (l[m_own]) m_own = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (sop[i] && i != g && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      if (b[i]) m_in[i] = !l[i];
    end
    @(posedge clk);
    #1;
    check("valid", out_TVALID, x_v);
    check("last", out_TLAST, x_l);
    check("busy", busy, m_own >= 0);
    check("data", out_TDATA, x_dat);
    check("keep", out_TKEEP, x_keep);
    check("chan", out_chan, x_chan);
    check("drop_cnt", drop_cnt, exp_cnt());
  endtask
  initial begin
    mreset();
    #12;
    check("rst_valid", out_TVALID, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_TDATA, 0);
    check("rst_chan", out_chan, 0);
    check("rst_tready", out_TREADY, 1);
    check("rst_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b001, 3'b111, 3'b000, 1'b1);
    step(3'b001, 3'b111, 3'b000, 1'b1);
    step(3'b001, 3'b111, 3'b001, 1'b1);
    step(3'b011, 3'b111, 3'b011, 1'b1);
    step(3'b011, 3'b111, 3'b011, 1'b1);
    step(3'b111, 3'b111, 3'b111, 1'b1);
    step(3'b001, 3'b111, 3'b000, 1'b1);
    step(3'b011, 3'b111, 3'b000, 1'b1);
    step(3'b011, 3'b111, 3'b010, 1'b1);
    step(3'b001, 3'b111, 3'b001, 1'b1);
    repeat (4) step(3'b001, 3'b111, 3'b001, 1'b1);
    step(3'b100, 3'b111, 3'b000, 1'b1);
    step(3'b000, 3'b111, 3'b000, 1'b0);
    step(3'b100, 3'b111, 3'b100, 1'b0);
    repeat (9) step(3'b010, 3'b111, 3'b010, 1'b0);
    step(3'b010, 3'b101, 3'b000, 1'b1);
    step(3'b001, 3'b111, 3'b000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_TVALID, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", drop_cnt, 0);
    mreset();
    sn_TVALID = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b001, 3'b111, 3'b000, 1'b1);
    step(3'b001, 3'b111, 3'b001, 1'b1);
    repeat (3000)
      step(N'($urandom) & N'($urandom), ~(N'($urandom) & N'($urandom) & N'($urandom)),
           N'($urandom) & N'($urandom), $urandom_range(0, 7) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
